if_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the branch predictor.
- Owns the architectural fetch PC and drives it to the predictor lookup.
- Issues word fetches to the memory controller over a req/ready handshake.
- Hands {inst, pc, predicted next pc, predicted-taken, predictor index} to decode; takes redirects from EX on mispredict and keeps the 1-bit global history fed to the predictor.

---
 rtl/if_fetch_pkg.sv | 32 +++
 rtl/if_fetch.sv | 220 ++++++++++++++++++++++
 tb/tb_if_fetch.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - default widths and reset PC (IF_ADDR_W, IF_BR_IDX_W, IF_RESET_PC)
//   - fetch FSM state encoding (ST_REQ / ST_OUT / ST_DROP / ST_HALT)
//   - TRUE / FALSE / ZERO_WORD constants
//   - pc_misaligned() helper used by the optional alignment check
//     (IF_MISALIGN_CHK_EN)
// -----------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int          IF_ADDR_W   = 32;
    localparam int          IF_BR_IDX_W = 6;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    localparam logic        TRUE      = 1'b1;
    localparam logic        FALSE     = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // ST_HALT is only reachable when IF_MISALIGN_CHK_EN is defined.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_OUT  = 2'd1,
        ST_DROP = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_t;

    function automatic logic pc_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage sitting directly upstream of the branch predictor.
// Owns the architectural fetch PC, issues one word fetch at a time to the
// memory controller and hands the returned instruction plus its prediction
// to decode. EX redirects (flush_i) override everything else.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_o, global_o      fetch PC and 1-bit global history to the predictor
//   prd_pc_i, prd_jmp_i, br_index_i
//                       predictor answer for pc_o (combinational)
//   mem_req, mem_addr   fetch request / word address to memory
//   mem_ready, mem_rdata
//                       one-cycle completion pulse with instruction data
//   if_valid, if_inst, if_pc, if_prd_pc, if_prd_jmp, if_br_index
//                       decode-side output bundle
//   id_ready            decode takes if_valid this cycle
//   flush_i, redirect_pc_i
//                       EX mispredict and correct next PC
//   br_resolve_i, br_taken_i
//                       resolved conditional branch, updates global history
//   misalign_o          (only with IF_MISALIGN_CHK_EN) sticky misaligned-PC flag
//   dbg_state           current FSM state, for observation only
//
// Handshakes:
//   memory : mem_req stays high with a stable mem_addr until the cycle
//            mem_ready pulses; that pulse both accepts the request and
//            returns mem_rdata. A request dropped by a flush may still
//            complete later; its data is discarded in ST_DROP.
//   decode : if_valid with its bundle is held stable until a cycle with
//            id_ready=1, which consumes it on that clock edge.
//
// Build option: define IF_MISALIGN_CHK_EN to add misalign_o and the ST_HALT
// trap for PCs whose bits [1:0] are non-zero. Without it the low PC bits
// pass straight through to mem_addr.
// -----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                BR_IDX_W = IF_BR_IDX_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,

    output logic [ADDR_W-1:0]   pc_o,
    output logic                global_o,
    input  logic [ADDR_W-1:0]   prd_pc_i,
    input  logic                prd_jmp_i,
    input  logic [BR_IDX_W-1:0] br_index_i,

    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ready,
    input  logic [31:0]         mem_rdata,

    output logic                if_valid,
    output logic [31:0]         if_inst,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [ADDR_W-1:0]   if_prd_pc,
    output logic                if_prd_jmp,
    output logic [BR_IDX_W-1:0] if_br_index,
    input  logic                id_ready,

    input  logic                flush_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    input  logic                br_resolve_i,
    input  logic                br_taken_i,
`ifdef IF_MISALIGN_CHK_EN
    output logic                misalign_o,
`endif
    output fetch_state_t        dbg_state
);

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic                global_q;
    logic                mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic                valid_d;
    logic                capture;
    logic                enter_req;

`ifdef IF_MISALIGN_CHK_EN
    logic                misalign_q;
    logic                pc_loaded;
    assign misalign_o = misalign_q;
`endif

    assign pc_o      = pc_q;
    assign global_o  = global_q;
    assign dbg_state = state_q;

    // Next-state logic. flush_i is evaluated first and wins over both
    // mem_ready and id_ready. Every transition into ST_REQ goes through
    // enter_req so that mem_req and mem_addr are loaded together and
    // mem_addr never moves while a request is outstanding.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req;
        mem_addr_d = mem_addr;
        valid_d    = if_valid;
        capture    = FALSE;
        enter_req  = FALSE;

        if (flush_i) begin
            pc_d    = redirect_pc_i;
            valid_d = FALSE;
            case (state_q)
                ST_REQ: begin
                    // Nothing outstanding (first cycle after reset) or the
                    // request completes right now: restart immediately.
                    if (mem_ready || !mem_req) begin
                        enter_req = TRUE;
                    end else begin
                        state_d   = ST_DROP;
                        mem_req_d = FALSE;
                    end
                end
                ST_OUT:  enter_req = TRUE;
                ST_DROP: if (mem_ready) enter_req = TRUE;
                default: ;
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (!mem_req) begin
                        // Reset leaves ST_REQ with mem_req low; raise it here.
                        mem_req_d  = TRUE;
                        mem_addr_d = pc_q;
                    end else if (mem_ready) begin
                        capture   = TRUE;
                        valid_d   = TRUE;
                        pc_d      = prd_pc_i;
                        state_d   = ST_OUT;
                        mem_req_d = FALSE;
                    end
                end
                ST_OUT: begin
                    if (id_ready) begin
                        valid_d   = FALSE;
                        enter_req = TRUE;
                    end
                end
                ST_DROP: if (mem_ready) enter_req = TRUE;
                default: ;
            endcase
        end

        if (enter_req) begin
            state_d    = ST_REQ;
            mem_req_d  = TRUE;
            mem_addr_d = pc_d;
        end

`ifdef IF_MISALIGN_CHK_EN
        // Any freshly loaded PC (redirect or prediction) is checked; a
        // misaligned one parks the stage until reset.
        pc_loaded = (flush_i || capture) && (state_q != ST_HALT);
        if (pc_loaded && pc_misaligned(pc_d[1:0])) begin
            state_d   = ST_HALT;
            mem_req_d = FALSE;
            valid_d   = FALSE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            global_q    <= FALSE;
            mem_req     <= FALSE;
            mem_addr    <= '0;
            if_valid    <= FALSE;
            if_inst     <= ZERO_WORD;
            if_pc       <= '0;
            if_prd_pc   <= '0;
            if_prd_jmp  <= FALSE;
            if_br_index <= '0;
`ifdef IF_MISALIGN_CHK_EN
            misalign_q  <= FALSE;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            mem_req  <= mem_req_d;
            mem_addr <= mem_addr_d;
            if_valid <= valid_d;

            // Global history tracks every resolved branch, whatever the
            // fetch side is doing.
            if (br_resolve_i) begin
                global_q <= br_taken_i;
            end

            // pc_q is frozen while in ST_REQ, so the predictor answer seen
            // here belongs to the instruction being captured.
            if (capture) begin
                if_inst     <= mem_rdata;
                if_pc       <= pc_q;
                if_prd_pc   <= prd_pc_i;
                if_prd_jmp  <= prd_jmp_i;
                if_br_index <= br_index_i;
            end

`ifdef IF_MISALIGN_CHK_EN
            if (state_d == ST_HALT) begin
                misalign_q <= TRUE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch
// Directed bench for if_fetch. A small memory responder returns
// {16'hC0DE, addr[15:0]} a fixed 3 cycles after it first sees a request,
// and a one-entry predictor stub answers "taken to 0x40" for pc 0x8 and
// pc+4 otherwise, with index {global_o, pc_o[6:2]}.
// Scenarios run back to back from one initial block; each starts where
// the previous one left the DUT.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int AW      = 32;
    localparam int BW      = 6;
    localparam int MEM_LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_o;
    logic          global_o;
    logic [AW-1:0] prd_pc_i;
    logic          prd_jmp_i;
    logic [BW-1:0] br_index_i;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          if_valid;
    logic [31:0]   if_inst;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_prd_pc;
    logic          if_prd_jmp;
    logic [BW-1:0] if_br_index;
    logic          id_ready;
    logic          flush_i;
    logic [AW-1:0] redirect_pc_i;
    logic          br_resolve_i;
    logic          br_taken_i;
    fetch_state_t  dbg_state;
`ifdef IF_MISALIGN_CHK_EN
    logic          misalign_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] req_log[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_o         (pc_o),
        .global_o     (global_o),
        .prd_pc_i     (prd_pc_i),
        .prd_jmp_i    (prd_jmp_i),
        .br_index_i   (br_index_i),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .if_valid     (if_valid),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .if_prd_pc    (if_prd_pc),
        .if_prd_jmp   (if_prd_jmp),
        .if_br_index  (if_br_index),
        .id_ready     (id_ready),
        .flush_i      (flush_i),
        .redirect_pc_i(redirect_pc_i),
        .br_resolve_i (br_resolve_i),
        .br_taken_i   (br_taken_i),
`ifdef IF_MISALIGN_CHK_EN
        .misalign_o   (misalign_o),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- predictor stub ----------------
    logic [AW-1:0] tk_pc;
    logic [AW-1:0] tk_target;
    assign prd_jmp_i  = (pc_o == tk_pc);
    assign prd_pc_i   = prd_jmp_i ? tk_target : (pc_o + 32'd4);
    assign br_index_i = {global_o, pc_o[6:2]};

    function automatic logic [31:0] rdata_of(input logic [AW-1:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // ---------------- memory responder ----------------
    // Runs 1 time unit after each rising edge; the test tasks sample at +3.
    logic          mem_busy;
    int            mem_cnt;
    logic [AW-1:0] mem_cur;
    initial begin
        mem_busy  = 1'b0;
        mem_cnt   = 0;
        mem_cur   = '0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (mem_busy) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata_of(mem_cur);
                    mem_busy  = 1'b0;
                end
            end else if (mem_req === 1'b1) begin
                mem_busy = 1'b1;
                mem_cur  = mem_addr;
                mem_cnt  = MEM_LAT - 1;
                req_log.push_back(mem_addr);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (if_valid !== 1'b1 && cycles < 20);
        if (if_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: if_valid not seen within %0d cycles", cycles);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %h, expected 0", mem_req); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid: got %h, expected 0", if_valid); end
        n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h, expected 0", pc_o); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h, expected 0", mem_addr); end
        n_checks++; if (global_o !== 1'b0) begin n_fail++; $display("FAIL rst_global: got %h, expected 0", global_o); end
        n_checks++; if ({if_inst, if_pc, if_prd_pc, if_prd_jmp, if_br_index} !== '0) begin
            n_fail++; $display("FAIL rst_if_data: got %h/%h/%h/%h/%h, expected all 0", if_inst, if_pc, if_prd_pc, if_prd_jmp, if_br_index);
        end
        n_checks++; if (dbg_state !== ST_REQ) begin n_fail++; $display("FAIL rst_state: got %0d, expected %0d", dbg_state, ST_REQ); end
        rst = 1'b0;
        step();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %h, expected 1", mem_req); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h, expected 0", mem_addr); end
    endtask

    task automatic test_fetch_stream();
        int            cyc;
        int            exp_cyc;
        logic [AW-1:0] exp_pc;
        logic [AW-1:0] got;
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc  = AW'(i * 4);
            exp_cyc = (i == 0) ? MEM_LAT : MEM_LAT + 1;
            exp_q.push_back(exp_pc);
            wait_valid(cyc);
            n_checks++; if (cyc != exp_cyc) begin n_fail++; $display("FAIL stream_spacing%0d: got %0d, expected %0d", i, cyc, exp_cyc); end
            n_checks++; if (if_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc%0d: got %h, expected %h", i, if_pc, exp_pc); end
            n_checks++; if (if_inst !== rdata_of(exp_pc)) begin n_fail++; $display("FAIL stream_inst%0d: got %h, expected %h", i, if_inst, rdata_of(exp_pc)); end
            n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL stream_req_out%0d: got %h, expected 0", i, mem_req); end
        end
        n_checks++; if (if_prd_jmp !== 1'b1 && if_pc !== 32'h8) begin n_fail++; $display("FAIL stream_last_pc: got %h, expected 8", if_pc); end
        n_checks++; if (req_log.size() != exp_q.size()) begin n_fail++; $display("FAIL stream_req_count: got %0d, expected %0d", req_log.size(), exp_q.size()); end
        while (exp_q.size() > 0 && req_log.size() > 0) begin
            got = req_log.pop_front();
            n_checks++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL stream_mem_addr: got %h, expected %h", got, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        exp_q.delete();
    endtask

    task automatic test_predict_taken();
        // Positioned on the valid cycle of pc 0x8.
        n_checks++; if (if_prd_jmp !== 1'b1) begin n_fail++; $display("FAIL taken_jmp: got %h, expected 1", if_prd_jmp); end
        n_checks++; if (if_prd_pc !== 32'h40) begin n_fail++; $display("FAIL taken_prd_pc: got %h, expected 40", if_prd_pc); end
        n_checks++; if (if_br_index !== 6'h02) begin n_fail++; $display("FAIL taken_index: got %h, expected 02", if_br_index); end
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL taken_next_addr: got req=%h addr=%h, expected req=1 addr=40", mem_req, mem_addr); end
    endtask

    task automatic test_stall();
        int cyc;
        id_ready = 1'b0;
        wait_valid(cyc);
        n_checks++; if (if_pc !== 32'h40) begin n_fail++; $display("FAIL stall_pc: got %h, expected 40", if_pc); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (if_valid !== 1'b1 || if_inst !== rdata_of(32'h40) || mem_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: got valid=%h inst=%h req=%h, expected valid=1 inst=%h req=0", k, if_valid, if_inst, mem_req, rdata_of(32'h40));
            end
            step();
        end
        id_ready = 1'b1;
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release_valid: got %h, expected 1", if_valid); end
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin n_fail++; $display("FAIL stall_next_req: got req=%h addr=%h, expected req=1 addr=44", mem_req, mem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_consumed: got %h, expected 0", if_valid); end
    endtask

    task automatic test_flush_drop();
        int cyc;
        step();
        flush_i       = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        flush_i = 1'b0;
        n_checks++; if (dbg_state !== ST_DROP) begin n_fail++; $display("FAIL drop_state: got %0d, expected %0d", dbg_state, ST_DROP); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL drop_req: got %h, expected 0", mem_req); end
        n_checks++; if (pc_o !== 32'h100) begin n_fail++; $display("FAIL drop_pc: got %h, expected 100", pc_o); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid_a: got %h, expected 0", if_valid); end
        step();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid_b: got %h, expected 0", if_valid); end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL drop_next_req: got req=%h addr=%h, expected req=1 addr=100", mem_req, mem_addr); end
        wait_valid(cyc);
        n_checks++; if (if_pc !== 32'h100 || if_inst !== rdata_of(32'h100)) begin n_fail++; $display("FAIL drop_refetch: got pc=%h inst=%h, expected pc=100 inst=%h", if_pc, if_inst, rdata_of(32'h100)); end
    endtask

    task automatic test_flush_with_ready();
        int cyc;
        int guard;
        guard = 0;
        do begin
            step();
            guard++;
        end while (mem_ready !== 1'b1 && guard < 10);
        n_checks++; if (mem_ready !== 1'b1 || pc_o !== 32'h104) begin n_fail++; $display("FAIL fr_setup: got ready=%h pc=%h, expected ready=1 pc=104", mem_ready, pc_o); end
        flush_i       = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        flush_i = 1'b0;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL fr_req: got req=%h addr=%h, expected req=1 addr=100", mem_req, mem_addr); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fr_discard: got %h, expected 0", if_valid); end
        n_checks++; if (dbg_state !== ST_REQ) begin n_fail++; $display("FAIL fr_state: got %0d, expected %0d", dbg_state, ST_REQ); end
        wait_valid(cyc);
        n_checks++; if (cyc != MEM_LAT || if_pc !== 32'h100) begin n_fail++; $display("FAIL fr_refetch: got cyc=%0d pc=%h, expected cyc=%0d pc=100", cyc, if_pc, MEM_LAT); end
    endtask

    task automatic test_global();
        int cyc;
        br_resolve_i = 1'b1;
        br_taken_i   = 1'b1;
        step();
        br_resolve_i = 1'b0;
        n_checks++; if (global_o !== 1'b1) begin n_fail++; $display("FAIL global_set: got %h, expected 1", global_o); end
        wait_valid(cyc);
        n_checks++; if (if_pc !== 32'h104 || if_br_index !== 6'h21) begin n_fail++; $display("FAIL global_index: got pc=%h idx=%h, expected pc=104 idx=21", if_pc, if_br_index); end
        br_resolve_i = 1'b1;
        br_taken_i   = 1'b0;
        step();
        n_checks++; if (global_o !== 1'b0) begin n_fail++; $display("FAIL global_clear: got %h, expected 0", global_o); end
        br_resolve_i = 1'b0;
        br_taken_i   = 1'b1;
        step();
        n_checks++; if (global_o !== 1'b0) begin n_fail++; $display("FAIL global_hold: got %h, expected 0", global_o); end
        br_taken_i = 1'b0;
    endtask

    task automatic test_wrap();
        int cyc;
        wait_valid(cyc);
        // Flush and id_ready together in OUT: the redirect target must win.
        flush_i       = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        flush_i = 1'b0;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL wrap_redirect: got req=%h addr=%h valid=%h, expected req=1 addr=fffffffc valid=0", mem_req, mem_addr, if_valid);
        end
        wait_valid(cyc);
        n_checks++; if (if_pc !== 32'hFFFF_FFFC || if_prd_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pred: got pc=%h prd=%h, expected pc=fffffffc prd=0", if_pc, if_prd_pc); end
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got req=%h addr=%h, expected req=1 addr=0", mem_req, mem_addr); end
    endtask

    task automatic test_misalign();
        int cyc;
        wait_valid(cyc);
        flush_i       = 1'b1;
        redirect_pc_i = 32'h102;
        step();
        flush_i = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        n_checks++; if (misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %h, expected 1", misalign_o); end
        n_checks++; if (dbg_state !== ST_HALT) begin n_fail++; $display("FAIL mis_state: got %0d, expected %0d", dbg_state, ST_HALT); end
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL mis_quiet%0d: got req=%h valid=%h, expected 0/0", k, mem_req, if_valid); end
            step();
        end
`else
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h102) begin n_fail++; $display("FAIL mis_passthru: got req=%h addr=%h, expected req=1 addr=102", mem_req, mem_addr); end
        wait_valid(cyc);
        n_checks++; if (if_pc !== 32'h102 || if_inst !== rdata_of(32'h102)) begin n_fail++; $display("FAIL mis_fetch: got pc=%h inst=%h, expected pc=102 inst=%h", if_pc, if_inst, rdata_of(32'h102)); end
`endif
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst           = 1'b1;
        id_ready      = 1'b0;
        flush_i       = 1'b0;
        redirect_pc_i = '0;
        br_resolve_i  = 1'b0;
        br_taken_i    = 1'b0;
        tk_pc         = 32'h8;
        tk_target     = 32'h40;

        test_reset();
        test_fetch_stream();
        test_predict_taken();
        test_stall();
        test_flush_drop();
        test_flush_with_ready();
        test_global();
        test_wrap();
        test_misalign();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
